// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// Define MULDIV_ABORT_EN to let flush abandon an in-flight operation.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t state, state_next;

  // acc holds {product_hi, product_lo} for multiply, {remainder, quotient} for divide
  logic [ACC_W-1:0] acc, acc_next;
  logic [WIDTH-1:0] opb, opb_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             is_div, is_div_next;
  logic             neg_q, neg_q_next;
  logic             neg_r, neg_r_next;
  logic             busy_next, done_next;
  logic [WIDTH-1:0] hi_next, lo_next;

  logic             muldiv_req;
  logic             start;
  logic             abort;
  logic             last;
  logic             is_signed;
  logic             sign_a, sign_b;
  logic             div_by_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Operand conditioning for a new operation
  assign muldiv_req  = op_valid && (state == IDLE) && (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_signed   = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a      = is_signed & rs[WIDTH-1];
  assign sign_b      = is_signed & rt[WIDTH-1];
  assign abs_a       = sign_a ? (~rs + WIDTH'(1)) : rs;
  assign abs_b       = sign_b ? (~rt + WIDTH'(1)) : rt;
  assign div_by_zero = (rt == '0);
  assign last        = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_ABORT_EN
  assign abort = flush && (state != IDLE);
  assign start = muldiv_req && !flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign abort        = 1'b0;
  assign start        = muldiv_req;
`endif

  // Shift-add multiply step: add multiplicand on LSB, then shift the whole accumulator right
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder, keep the subtraction if it fits
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_rem;
  logic [ACC_W-1:0] div_step;
  logic             unused_div_msb;
  assign div_shifted    = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
  assign div_diff       = {1'b0, div_shifted} - {2'b00, opb};
  assign div_fits       = ~div_diff[WIDTH+1];
  assign div_rem        = div_fits ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
  assign div_step       = {div_rem, acc[WIDTH-2:0], div_fits};
  assign unused_div_msb = div_diff[WIDTH];

  // Sign fixup of the raw magnitudes
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_q ? (~acc + ACC_W'(1)) : acc;
  assign quo_fix  = neg_q ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? (~acc[ACC_W-1:WIDTH] + WIDTH'(1)) : acc[ACC_W-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last)  state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_next    = acc;
    opb_next    = opb;
    cnt_next    = cnt;
    is_div_next = is_div;
    neg_q_next  = neg_q;
    neg_r_next  = neg_r;
    hi_next     = hi;
    lo_next     = lo;
    done_next   = 1'b0;
    busy_next   = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          acc_next    = {{WIDTH{1'b0}}, abs_a};
          opb_next    = abs_b;
          cnt_next    = '0;
          is_div_next = (op == OP_DIV) || (op == OP_DIVU);
          // a zero divisor leaves the all-ones quotient un-negated
          neg_q_next  = (sign_a ^ sign_b) &
                        !(((op == OP_DIV) || (op == OP_DIVU)) && div_by_zero);
          neg_r_next  = sign_a;
        end else if (op_valid && op == OP_MTHI) begin
          hi_next = rs;
        end else if (op_valid && op == OP_MTLO) begin
          lo_next = rs;
        end
      end
      CALC: begin
        acc_next = is_div ? div_step : mul_step;
        cnt_next = cnt + CNT_W'(1);
      end
      FIXUP: begin
        done_next = 1'b1;
        if (is_div) begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end else begin
          hi_next = prod_fix[ACC_W-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
    if (abort) begin
      done_next = 1'b0;
      hi_next   = hi;
      lo_next   = lo;
    end
  end

  // Output logic: hold the pipeline while anything is issued to a busy unit
  always_comb begin
    stall = op_valid && (op != OP_NONE) && (state != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      acc    <= acc_next;
      opb    <= opb_next;
      cnt    <= cnt_next;
      is_div <= is_div_next;
      neg_q  <= neg_q_next;
      neg_r  <= neg_r_next;
      busy   <= busy_next;
      done   <= done_next;
      hi     <= hi_next;
      lo     <= lo_next;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random ops
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       op;
  logic             op_valid;
  logic [WIDTH-1:0] rs, rt;
  logic             flush;
  logic             busy, stall, done;
  logic [WIDTH-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_hi = '0;
  logic [WIDTH-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .op_valid(op_valid), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      3'd1: begin p = sa * sb; return 64'(p); end
      3'd2: return 64'(ua * ub);
      3'd3: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b == 0) return {a, 32'hFFFF_FFFF};
            else return {32'(ua % ub), 32'(ua / ub)};
      default: return 64'h0;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs = a; rt = b; op_valid = 1'b1;
    check("stall at issue", stall, 0);
    tick();
    op_valid = 1'b0; op = 3'd0;
    check("busy after start", busy, 1);
  endtask

  // Wait for done, n0 = cycles already elapsed since the start edge
  task automatic wait_done(input logic [31:0] e_hi, input logic [31:0] e_lo, input bit hold_mf, input int n0);
    int  n;
    int  busy_cnt;
    bit  stall_bad;
    n = n0; busy_cnt = n0; stall_bad = 0;
    if (hold_mf) begin op = 3'd7; op_valid = 1'b1; end
    while (!done && n < 200) begin
      if (hold_mf && !stall) stall_bad = 1;
      if (n == WIDTH / 2) begin
        check("hi held in calc", hi, exp_hi);
        check("lo held in calc", lo, exp_lo);
      end
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    check("latency", n, LAT);
    check("busy cycles", busy_cnt, LAT - 1);
    check("busy low at done", busy, 0);
    check("hi result", hi, e_hi);
    check("lo result", lo, e_lo);
    if (hold_mf) begin
      check("stall while busy", stall_bad, 0);
      check("stall released on done", stall, 0);
      op_valid = 1'b0; op = 3'd0;
    end
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, h, l;
  } vec_t;

  vec_t dir[9] = '{
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
    '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
    '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
    '{3'd4, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF},
    '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF},
    '{3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E},
    '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD}
  };

  initial begin
    logic [63:0] e;
    logic [2:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; rs = '0; rt = '0; flush = 1'b0;
    repeat (3) tick();
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst_n = 1'b1;
    tick();

    foreach (dir[i]) begin
      start_op(dir[i].o, dir[i].a, dir[i].b);
      wait_done(dir[i].h, dir[i].l, 1'b0, 1);
      tick();
      check("done one cycle", done, 0);
    end

    // MTHI / MTLO in IDLE, then MF held behind a DIVU
    op = 3'd5; rs = 32'h1234_5678; op_valid = 1'b1;
    check("stall on mthi", stall, 0);
    tick();
    op_valid = 1'b0;
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi lo untouched", lo, exp_lo);
    exp_hi = 32'h1234_5678;
    op = 3'd6; rs = 32'h0BAD_F00D; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    check("mtlo lo", lo, 32'h0BAD_F00D);
    exp_lo = 32'h0BAD_F00D;
    start_op(3'd4, 32'd1000, 32'd3);
    wait_done(32'd1, 32'd333, 1'b1, 1);
    tick();

    // Random operations, some issued back-to-back on the done cycle
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(1, 4));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      e = model(o, a, b);
      start_op(o, a, b);
      wait_done(e[63:32], e[31:0], 1'b0, 1);
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check("done one cycle rnd", done, 0);
      end
    end
    tick();

    // Reset in the middle of CALC discards everything
    start_op(3'd2, 32'($urandom), 32'($urandom));
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    exp_hi = '0; exp_lo = '0;
    tick();

    // Flush in the middle of CALC
    op = 3'd5; rs = 32'hCAFE_0001; op_valid = 1'b1; tick();
    op = 3'd6; rs = 32'hCAFE_0002; tick();
    op_valid = 1'b0;
    exp_hi = 32'hCAFE_0001; exp_lo = 32'hCAFE_0002;
    a = 32'($urandom); b = 32'($urandom);
    e = model(3'd1, a, b);
    start_op(3'd1, a, b);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef MULDIV_ABORT_EN
    begin
      bit saw_done;
      saw_done = 0;
      check("abort busy", busy, 0);
      for (int c = 0; c < LAT; c++) begin
        if (done) saw_done = 1;
        tick();
      end
      check("abort no done", saw_done, 0);
      check("abort hi kept", hi, exp_hi);
      check("abort lo kept", lo, exp_lo);
      op = 3'd2; rs = 32'd5; rt = 32'd6; op_valid = 1'b1; flush = 1'b1;
      tick();
      op_valid = 1'b0; flush = 1'b0; op = 3'd0;
      check("flushed start dropped", busy, 0);
      start_op(3'd2, 32'd5, 32'd6);
      wait_done(32'd0, 32'd30, 1'b0, 1);
    end
`else
    wait_done(e[63:32], e[31:0], 1'b0, 11);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
